// File: rtl/shift_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : shift_arbiter                                                |
// | Description : Two-port valid/ready arbiter in front of a shared 16-bit     |
// |               barrel shifter. Latches the granted operation, drives the    |
// |               shifter from registered operands, captures the result and    |
// |               returns it on a single id-tagged response port.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module shift_arbiter #(
  parameter int RR_EN = 1  // 1: round-robin between ports, 0: port 0 always wins
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r0_valid,
  output logic        r0_ready,
  input  logic [15:0] r0_data,
  input  logic [3:0]  r0_cnt,
  input  logic [1:0]  r0_op,
  input  logic        r1_valid,
  output logic        r1_ready,
  input  logic [15:0] r1_data,
  input  logic [3:0]  r1_cnt,
  input  logic [1:0]  r1_op,
  output logic [15:0] shf_in,
  output logic [3:0]  shf_cnt,
  output logic [1:0]  shf_op,
  input  logic [15:0] shf_out,
  output logic        resp_valid,
  output logic        resp_id,
  output logic [15:0] resp_data,
  input  logic        resp_ready,
  output logic        busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        ptr_q, ptr_d;
  logic [15:0] opd_data_q, opd_data_d;
  logic [3:0]  opd_cnt_q, opd_cnt_d;
  logic [1:0]  opd_op_q, opd_op_d;
  logic        opd_id_q, opd_id_d;
  logic [15:0] resp_data_q, resp_data_d;

  logic        grant_id;
  logic        accept;

  // Grant selection and request readies; readies only ever open in IDLE and
  // are held low while reset is asserted.
  always_comb begin
    grant_id = 1'b0;
    if (r0_valid && r1_valid) begin
      grant_id = ptr_q;
    end else if (r1_valid) begin
      grant_id = 1'b1;
    end
    r0_ready = !rst && (state_q == IDLE) && r0_valid && (grant_id == 1'b0);
    r1_ready = !rst && (state_q == IDLE) && r1_valid && (grant_id == 1'b1);
    accept   = r0_ready || r1_ready;
  end

  // Next-state, operand capture, result capture and round-robin pointer update.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    opd_data_d  = opd_data_q;
    opd_cnt_d   = opd_cnt_q;
    opd_op_d    = opd_op_q;
    opd_id_d    = opd_id_q;
    resp_data_d = resp_data_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          opd_data_d = grant_id ? r1_data : r0_data;
          opd_cnt_d  = grant_id ? r1_cnt  : r0_cnt;
          opd_op_d   = grant_id ? r1_op   : r0_op;
          opd_id_d   = grant_id;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        resp_data_d = shf_out;
        state_d     = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
          // Pointer stays at 0 forever in fixed-priority mode.
          if (RR_EN != 0) begin
            ptr_d = ~opd_id_q;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      opd_data_q  <= 16'h0000;
      opd_cnt_q   <= 4'h0;
      opd_op_q    <= 2'b00;
      opd_id_q    <= 1'b0;
      resp_data_q <= 16'h0000;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      opd_data_q  <= opd_data_d;
      opd_cnt_q   <= opd_cnt_d;
      opd_op_q    <= opd_op_d;
      opd_id_q    <= opd_id_d;
      resp_data_q <= resp_data_d;
    end
  end

  // Shifter is always driven from the operand registers, even outside EXEC.
  assign shf_in     = opd_data_q;
  assign shf_cnt    = opd_cnt_q;
  assign shf_op     = opd_op_q;

  assign resp_valid = (state_q == RESP);
  assign resp_id    = opd_id_q;
  assign resp_data  = resp_data_q;
  assign busy       = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_shift_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_shift_arbiter                                             |
// | Description : Directed self-checking bench for shift_arbiter. A round-     |
// |               robin instance and a fixed-priority instance share stimulus. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_shift_arbiter;

  logic        clk;
  logic        rst;
  logic        r0_valid, r1_valid;
  logic [15:0] r0_data, r1_data;
  logic [3:0]  r0_cnt, r1_cnt;
  logic [1:0]  r0_op, r1_op;
  logic        resp_ready;

  logic        r0_ready, r1_ready, resp_valid, resp_id, busy;
  logic [15:0] shf_in, shf_out, resp_data;
  logic [3:0]  shf_cnt;
  logic [1:0]  shf_op;

  logic        fp_r0_ready, fp_r1_ready, fp_resp_valid, fp_resp_id, fp_busy;
  logic [15:0] fp_shf_in, fp_shf_out, fp_resp_data;
  logic [3:0]  fp_shf_cnt;
  logic [1:0]  fp_shf_op;

  int n_checks = 0;
  int n_errors = 0;

  // Reference barrel shifter standing in for the execute-stage shifter.
  function automatic logic [15:0] shifter(input logic [15:0] d, input logic [3:0] c,
                                          input logic [1:0] op);
    logic [31:0] w;
    case (op)
      2'b00:   w = {16'h0, d} << c;
      2'b01:   w = {16'h0, d} >> c;
      2'b10:   w = {{16{d[15]}}, d} >> c;
      default: w = ({16'h0, d} << c) | ({16'h0, d} >> (5'd16 - {1'b0, c}));
    endcase
    return w[15:0];
  endfunction

  assign shf_out    = shifter(shf_in, shf_cnt, shf_op);
  assign fp_shf_out = shifter(fp_shf_in, fp_shf_cnt, fp_shf_op);

  shift_arbiter #(.RR_EN(1)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_data(r0_data), .r0_cnt(r0_cnt), .r0_op(r0_op),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_data(r1_data), .r1_cnt(r1_cnt), .r1_op(r1_op),
    .shf_in(shf_in), .shf_cnt(shf_cnt), .shf_op(shf_op), .shf_out(shf_out),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
    .resp_ready(resp_ready), .busy(busy)
  );

  shift_arbiter #(.RR_EN(0)) dut_fp (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(fp_r0_ready), .r0_data(r0_data), .r0_cnt(r0_cnt), .r0_op(r0_op),
    .r1_valid(r1_valid), .r1_ready(fp_r1_ready), .r1_data(r1_data), .r1_cnt(r1_cnt), .r1_op(r1_op),
    .shf_in(fp_shf_in), .shf_cnt(fp_shf_cnt), .shf_op(fp_shf_op), .shf_out(fp_shf_out),
    .resp_valid(fp_resp_valid), .resp_id(fp_resp_id), .resp_data(fp_resp_data),
    .resp_ready(resp_ready), .busy(fp_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction with resp_ready held high.
  task automatic do_op(input string tag, input logic port, input logic [15:0] d,
                       input logic [3:0] c, input logic [1:0] op, input logic [15:0] exp);
    int waited;
    resp_ready = 1'b1;
    if (port) begin
      r1_valid = 1'b1; r1_data = d; r1_cnt = c; r1_op = op;
    end else begin
      r0_valid = 1'b1; r0_data = d; r0_cnt = c; r0_op = op;
    end
    #1;
    waited = 0;
    while (!(port ? r1_ready : r0_ready) && waited < 5) begin
      tick();
      waited++;
    end
    check({tag, "_ready"}, {31'h0, port ? r1_ready : r0_ready}, 32'h1);
    tick();
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    check({tag, "_exec_op"}, {30'h0, shf_op}, {30'h0, op});
    tick();
    check({tag, "_valid"}, {31'h0, resp_valid}, 32'h1);
    check({tag, "_data"}, {16'h0, resp_data}, {16'h0, exp});
    check({tag, "_id"}, {31'h0, resp_id}, {31'h0, port});
    tick();
    check({tag, "_idle"}, {31'h0, busy}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_rr, n_fp, resp_seen;
    logic id_rr [4];
    logic id_fp [4];
    logic [15:0] dat_rr [4];
    int cyc_rr [4];

    rst = 1'b1;
    r0_valid = 1'b1; r0_data = 16'h1234; r0_cnt = 4'd2; r0_op = 2'b00;
    r1_valid = 1'b0; r1_data = 16'h0; r1_cnt = 4'd0; r1_op = 2'b00;
    resp_ready = 1'b0;

    // Reset values
    tick(); tick();
    check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_resp_id", {31'h0, resp_id}, 32'h0);
    check("rst_resp_data", {16'h0, resp_data}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_shf", {10'h0, shf_in, shf_cnt, shf_op}, 32'h0);
    check("rst_r0_ready", {31'h0, r0_ready}, 32'h0);

    // Reset mid-operation
    rst = 1'b0;
    #1;
    check("mid_ready", {31'h0, r0_ready}, 32'h1);
    tick();
    check("mid_exec_busy", {31'h0, busy}, 32'h1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", {31'h0, busy}, 32'h0);
    check("mid_rst_valid", {31'h0, resp_valid}, 32'h0);
    check("mid_rst_ready", {31'h0, r0_ready}, 32'h0);
    tick();
    rst = 1'b0;
    #1;
    check("mid_post_ready", {31'h0, r0_ready}, 32'h1);
    r0_valid = 1'b0;
    resp_ready = 1'b1;
    resp_seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (resp_valid) resp_seen++;
    end
    check("mid_no_resp", resp_seen, 0);

    // Single request, latency and busy width
    r0_valid = 1'b1; r0_data = 16'h0001; r0_cnt = 4'd4; r0_op = 2'b00;
    #1;
    check("single_ready", {31'h0, r0_ready}, 32'h1);
    tick();
    r0_valid = 1'b0;
    check("single_c1_busy", {31'h0, busy}, 32'h1);
    check("single_c1_valid", {31'h0, resp_valid}, 32'h0);
    check("single_c1_shf", {10'h0, shf_in, shf_cnt, shf_op}, {10'h0, 16'h0001, 4'd4, 2'b00});
    tick();
    check("single_c2_valid", {31'h0, resp_valid}, 32'h1);
    check("single_c2_busy", {31'h0, busy}, 32'h1);
    check("single_data", {16'h0, resp_data}, 32'h0010);
    check("single_id", {31'h0, resp_id}, 32'h0);
    tick();
    check("single_c3_busy", {31'h0, busy}, 32'h0);
    check("single_c3_valid", {31'h0, resp_valid}, 32'h0);

    // Backpressure on port 1
    resp_ready = 1'b0;
    r1_valid = 1'b1; r1_data = 16'h00F0; r1_cnt = 4'd2; r1_op = 2'b01;
    #1;
    check("bp_ready", {31'h0, r1_ready}, 32'h1);
    tick();
    check("bp_exec_op", {30'h0, shf_op}, 32'h1);
    r0_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", {31'h0, resp_valid}, 32'h1);
      check("bp_data", {16'h0, resp_data}, 32'h003C);
      check("bp_id", {31'h0, resp_id}, 32'h1);
      check("bp_readies", {30'h0, r0_ready, r1_ready}, 32'h0);
      check("bp_busy", {31'h0, busy}, 32'h1);
    end
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    resp_ready = 1'b1;
    tick();
    check("bp_release_busy", {31'h0, busy}, 32'h0);
    check("bp_release_valid", {31'h0, resp_valid}, 32'h0);

    // Count boundaries and op pass-through
    do_op("cnt0", 1'b0, 16'h8001, 4'd0, 2'b00, 16'h8001);
    do_op("cnt15", 1'b0, 16'h8001, 4'd15, 2'b00, 16'h8000);
    do_op("sra", 1'b0, 16'h8000, 4'd3, 2'b10, 16'hF000);
    do_op("rol", 1'b1, 16'h8001, 4'd1, 2'b11, 16'h0003);

    // Contention: both ports continuously valid
    r0_valid = 1'b1; r0_data = 16'h0001; r0_cnt = 4'd1; r0_op = 2'b00;
    r1_valid = 1'b1; r1_data = 16'h0002; r1_cnt = 4'd1; r1_op = 2'b00;
    resp_ready = 1'b1;
    n_rr = 0;
    n_fp = 0;
    for (int cyc = 0; cyc < 13; cyc++) begin
      tick();
      if (resp_valid && n_rr < 4) begin
        id_rr[n_rr] = resp_id; dat_rr[n_rr] = resp_data; cyc_rr[n_rr] = cyc;
        n_rr++;
      end
      if (fp_resp_valid && n_fp < 4) begin
        id_fp[n_fp] = fp_resp_id;
        n_fp++;
      end
    end
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    check("rr_count", n_rr, 4);
    check("fp_count", n_fp, 4);
    for (int i = 0; i < 4; i++) begin
      if (i < n_rr) begin
        check("rr_id", {31'h0, id_rr[i]}, (i % 2 == 1) ? 32'h1 : 32'h0);
        check("rr_data", {16'h0, dat_rr[i]}, (i % 2 == 1) ? 32'h0004 : 32'h0002);
      end
      if (i < n_fp) check("fp_id", {31'h0, id_fp[i]}, 32'h0);
    end
    if (n_rr == 4) check("rr_interval", cyc_rr[3] - cyc_rr[0], 9);
    tick(); tick(); tick();
    check("final_idle", {30'h0, busy, fp_busy}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
